// File: rtl/vga_timing_gen_if.sv
// Signal bundle between the VGA timing generator, its pixel source and the DAC pins.
// test_en exists only when VGA_TIMING_TESTPAT_EN is defined.
interface vga_timing_gen_if #(
   parameter int unsigned CNT_W   = 11,
   parameter int unsigned COLOR_W = 8
);
   logic [3*COLOR_W-1:0] rgb_in;
   logic [CNT_W-1:0]     x_addr;
   logic [CNT_W-1:0]     y_addr;
   logic                 addr_valid;
   logic                 frame_start;
   logic                 vblank_start;
   logic [15:0]          frame_count;
   logic                 vga_hs;
   logic                 vga_vs;
   logic                 vga_de;
   logic [COLOR_W-1:0]   vga_r;
   logic [COLOR_W-1:0]   vga_g;
   logic [COLOR_W-1:0]   vga_b;
`ifdef VGA_TIMING_TESTPAT_EN
   logic                 test_en;

   modport master (
      input  rgb_in, test_en,
      output x_addr, y_addr, addr_valid, frame_start, vblank_start, frame_count,
             vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b
   );
   modport slave (
      output rgb_in, test_en,
      input  x_addr, y_addr, addr_valid, frame_start, vblank_start, frame_count,
             vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b
   );
`else
   modport master (
      input  rgb_in,
      output x_addr, y_addr, addr_valid, frame_start, vblank_start, frame_count,
             vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b
   );
   modport slave (
      output rgb_in,
      input  x_addr, y_addr, addr_valid, frame_start, vblank_start, frame_count,
             vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b
   );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-source lookahead and frame events.
// Define VGA_TIMING_TESTPAT_EN to add the test_en colour-bar generator.
module vga_timing_gen #(
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BACK      = 48,
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned H_FRONT     = 16,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BACK      = 33,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned V_FRONT     = 10,
   parameter bit          HS_POL      = 1'b0,
   parameter bit          VS_POL      = 1'b0,
   parameter int unsigned CNT_W       = 11,
   parameter int unsigned COLOR_W     = 8,
   parameter int unsigned PIX_LATENCY = 1
) (
   input logic              clock,
   input logic              reset,
   vga_timing_gen_if.master bus
);
   localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_SYNCW = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNCW = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] H_VIS0  = CNT_W'(H_SYNC + H_BACK);
   localparam logic [CNT_W-1:0] H_VIS1  = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [CNT_W-1:0] V_VIS0  = CNT_W'(V_SYNC + V_BACK);
   localparam logic [CNT_W-1:0] V_VIS1  = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);
   localparam logic [CNT_W-1:0] X_LAST  = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

`ifdef VGA_TIMING_TESTPAT_EN
   localparam int unsigned      DW    = 6;
   localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);
`else
   localparam int unsigned      DW    = 3;
`endif

   logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d;
   logic             hs_act, vs_act, vis;

   always_comb begin
      hc_d = hc_q + ONE;
      vc_d = vc_q;
      if (hc_q == H_LAST) begin
         hc_d = '0;
         vc_d = (vc_q == V_LAST) ? '0 : vc_q + ONE;
      end
   end

   assign hs_act = hc_q < H_SYNCW;
   assign vs_act = vc_q < V_SYNCW;
   assign vis    = (hc_q >= H_VIS0) && (hc_q < H_VIS1) && (vc_q >= V_VIS0) && (vc_q < V_VIS1);

   // Address stage
   logic [CNT_W-1:0] x_q, y_q;
   logic             av_q, fs_q, vbs_q, fs_d;
   logic [15:0]      fc_q;

   assign fs_d = vis && (hc_q == H_VIS0) && (vc_q == V_VIS0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hc_q  <= '0;
         vc_q  <= '0;
         x_q   <= '0;
         y_q   <= '0;
         av_q  <= 1'b0;
         fs_q  <= 1'b0;
         vbs_q <= 1'b0;
         fc_q  <= '0;
      end else begin
         hc_q  <= hc_d;
         vc_q  <= vc_d;
         x_q   <= vis ? hc_q - H_VIS0 : '0;
         y_q   <= vis ? vc_q - V_VIS0 : '0;
         av_q  <= vis;
         fs_q  <= fs_d;
         // Fires the cycle after the bottom-right pixel, independent of porch sizes
         vbs_q <= av_q && (x_q == X_LAST) && (y_q == Y_LAST);
         if (fs_d) fc_q <= fc_q + 16'd1;
      end
   end

   // Delay line: {bar index, hs, vs, de}; entry 0 is aligned with the address stage
   logic [DW-1:0] dly_d;
   logic [DW-1:0] dly_q [PIX_LATENCY+1];
   logic [DW-1:0] tail;

`ifdef VGA_TIMING_TESTPAT_EN
   logic [2:0]       bar_idx_q, bar_idx_d;
   logic [CNT_W-1:0] bar_cnt_q, bar_cnt_d;

   // bar_cnt counts pixels already emitted in the current bar; the last bar never advances
   always_comb begin
      bar_idx_d = bar_idx_q;
      bar_cnt_d = bar_cnt_q + ONE;
      if (!vis) begin
         bar_idx_d = 3'd0;
         bar_cnt_d = '0;
      end else if (!av_q) begin
         bar_idx_d = 3'd0;
         bar_cnt_d = ONE;
      end else if ((bar_cnt_q == BAR_W) && (bar_idx_q != 3'd7)) begin
         bar_idx_d = bar_idx_q + 3'd1;
         bar_cnt_d = ONE;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bar_idx_q <= '0;
         bar_cnt_q <= '0;
      end else begin
         bar_idx_q <= bar_idx_d;
         bar_cnt_q <= bar_cnt_d;
      end
   end

   assign dly_d = {bar_idx_d, hs_act, vs_act, vis};
`else
   assign dly_d = {hs_act, vs_act, vis};
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i <= PIX_LATENCY; i++) dly_q[i] <= '0;
      end else begin
         dly_q[0] <= dly_d;
         for (int unsigned i = 1; i <= PIX_LATENCY; i++) dly_q[i] <= dly_q[i-1];
      end
   end

   assign tail = dly_q[PIX_LATENCY];

   // Output stage
   logic [3*COLOR_W-1:0] rgb_d, rgb_q;
   logic                 hs_q, vs_q, de_q;

   always_comb begin
      rgb_d = '0;
      if (tail[0]) begin
         rgb_d = bus.rgb_in;
`ifdef VGA_TIMING_TESTPAT_EN
         // Bar order white, yellow, cyan, green, magenta, red, blue, black
         if (bus.test_en) begin
            rgb_d = {{COLOR_W{~tail[4]}}, {COLOR_W{~tail[5]}}, {COLOR_W{~tail[3]}}};
         end
`endif
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hs_q  <= ~HS_POL;
         vs_q  <= ~VS_POL;
         de_q  <= 1'b0;
         rgb_q <= '0;
      end else begin
         hs_q  <= tail[2] ? HS_POL : ~HS_POL;
         vs_q  <= tail[1] ? VS_POL : ~VS_POL;
         de_q  <= tail[0];
         rgb_q <= rgb_d;
      end
   end

   assign bus.x_addr       = x_q;
   assign bus.y_addr       = y_q;
   assign bus.addr_valid   = av_q;
   assign bus.frame_start  = fs_q;
   assign bus.vblank_start = vbs_q;
   assign bus.frame_count  = fc_q;
   assign bus.vga_hs       = hs_q;
   assign bus.vga_vs       = vs_q;
   assign bus.vga_de       = de_q;
   assign bus.vga_r        = rgb_q[3*COLOR_W-1:2*COLOR_W];
   assign bus.vga_g        = rgb_q[2*COLOR_W-1:COLOR_W];
   assign bus.vga_b        = rgb_q[COLOR_W-1:0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen on a small raster; expected values come from
// arithmetic on the cycle count since reset release and a random pixel memory.
module tb_vga_timing_gen;
   localparam int unsigned HS = 4, HB = 3, HA = 16, HF = 2;
   localparam int unsigned VS = 2, VB = 2, VA = 6, VF = 1;
   localparam bit          HPOL = 1'b1, VPOL = 1'b0;
   localparam int unsigned CNTW = 11, CW = 8, LAT = 2;
   localparam int HT = HS + HB + HA + HF;
   localparam int VT = VS + VB + VA + VF;
   localparam int F = HT * VT;
   localparam int HS0 = HS + HB;
   localparam int VS0 = VS + VB;
   localparam int S0 = VS0 * HT + HS0;
   localparam int S_LAST = (VS0 + VA - 1) * HT + HS0 + HA - 1;
   localparam int BW = HA / 8;

   logic clock = 1'b0;
   logic reset;
   logic tp;
   int   cyc;
   int   n_checks = 0;
   int   n_pass = 0;

   logic [23:0] mem [HA*VA];
   logic [23:0] bars [8];
   int          hist_x [8];
   int          hist_y [8];
   bit          hist_av [8];

   typedef struct {
      int          x, y, fc;
      bit          av, fs, vbs, hs, vs, de;
      logic [23:0] rgb;
   } exp_t;

   vga_timing_gen_if #(.CNT_W(CNTW), .COLOR_W(CW)) bus ();

   vga_timing_gen #(
      .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
      .HS_POL(HPOL), .VS_POL(VPOL), .CNT_W(CNTW), .COLOR_W(CW), .PIX_LATENCY(LAT)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

`ifdef VGA_TIMING_TESTPAT_EN
   assign bus.test_en = tp;
`endif

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      else n_pass++;
   endtask

   function automatic bit visible(input int h, input int v);
      return (h >= HS0) && (h < HS0 + HA) && (v >= VS0) && (v < VS0 + VA);
   endfunction

   // Expected outputs after n rising edges since reset release (n=0: in/at reset)
   function automatic exp_t model(input int n, input bit pat);
      exp_t e;
      int   s, h, v, o, bi;
      e.x = 0; e.y = 0; e.fc = 0; e.av = 0; e.fs = 0; e.vbs = 0;
      e.hs = !HPOL; e.vs = !VPOL; e.de = 0; e.rgb = '0;
      if (n >= 1) begin
         s = (n - 1) % F; h = s % HT; v = s / HT;
         e.av = visible(h, v);
         e.x  = e.av ? h - HS0 : 0;
         e.y  = e.av ? v - VS0 : 0;
         e.fs = (s == S0);
         e.fc = (n - 1 >= S0) ? (((n - 1 - S0) / F) + 1) % 65536 : 0;
      end
      if (n >= 2) e.vbs = ((n - 2) % F == S_LAST);
      o = n - 2 - LAT;
      if (o >= 0) begin
         s = o % F; h = s % HT; v = s / HT;
         e.hs = (h < HS) ? HPOL : !HPOL;
         e.vs = (v < VS) ? VPOL : !VPOL;
         e.de = visible(h, v);
         if (e.de) begin
            bi = (h - HS0) / BW;
            if (bi > 7) bi = 7;
            e.rgb = pat ? bars[bi] : mem[(v - VS0) * HA + (h - HS0)];
         end
      end
      return e;
   endfunction

   task automatic compare_all();
      exp_t e;
      e = model(cyc, tp);
      check("x_addr", 32'(bus.x_addr), 32'(e.x));
      check("y_addr", 32'(bus.y_addr), 32'(e.y));
      check("addr_valid", 32'(bus.addr_valid), 32'(e.av));
      check("frame_start", 32'(bus.frame_start), 32'(e.fs));
      check("vblank_start", 32'(bus.vblank_start), 32'(e.vbs));
      check("frame_count", 32'(bus.frame_count), 32'(e.fc));
      check("vga_hs", 32'(bus.vga_hs), 32'(e.hs));
      check("vga_vs", 32'(bus.vga_vs), 32'(e.vs));
      check("vga_de", 32'(bus.vga_de), 32'(e.de));
      check("vga_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(e.rgb));
   endtask

   // Pixel source with LAT cycles of read latency, fed from the DUT's address outputs
   task automatic drive_rgb();
      int k;
      hist_x[cyc % 8]  = 32'(bus.x_addr);
      hist_y[cyc % 8]  = 32'(bus.y_addr);
      hist_av[cyc % 8] = bus.addr_valid;
      k = (cyc - LAT) % 8;
      if (cyc - LAT >= 1 && hist_av[k]) bus.rgb_in = mem[hist_y[k] * HA + hist_x[k]];
      else bus.rgb_in = 24'($urandom);
   endtask

   task automatic run(input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clock);
         cyc++;
         @(negedge clock);
         compare_all();
         drive_rgb();
      end
   endtask

   initial begin
      bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
      bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
      for (int i = 0; i < HA * VA; i++) mem[i] = 24'($urandom);
      for (int i = 0; i < 8; i++) hist_av[i] = 1'b0;
      reset = 1'b1;
      tp = 1'b0;
      cyc = 0;
      bus.rgb_in = '0;
      repeat (2) @(negedge clock);
      compare_all();
      reset = 1'b0;
      run(3 * F + int'($urandom_range(0, F - 1)));

      // Asynchronous reset mid-frame: outputs must clear before the next edge
      #2 reset = 1'b1;
      cyc = 0;
      #1 compare_all();
      repeat (int'($urandom_range(1, 3))) begin
         @(negedge clock);
         compare_all();
      end
      reset = 1'b0;
      run(2 * F + int'($urandom_range(0, F - 1)));

`ifdef VGA_TIMING_TESTPAT_EN
      tp = 1'b1;
      run(F + int'($urandom_range(0, HT)));
      tp = 1'b0;
      run(HT * 2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It supersedes the fixed 640x480 controller and adds:
- configurable porch, sync and active widths and sync polarity;
- a pixel-source lookahead pipeline, so colour from RAM or ROM lines up with sync;
- frame and vblank event pulses and a frame counter for game-state updates.

It sits between the pixel clock domain's drawing logic (ball, paddles, score) and the board's VGA DAC pins.

## Interface
- `H_SYNC`, 96 — horizontal sync width, pixels
- `H_BACK`, 48 — horizontal back porch, pixels
- `H_ACTIVE`, 640 — visible pixels per line
- `H_FRONT`, 16 — horizontal front porch, pixels
- `V_SYNC`, 2 / `V_BACK`, 33 / `V_ACTIVE`, 480 / `V_FRONT`, 10 — same set, in lines
- `HS_POL`, 0 — active level of `vga_hs` (0 = active-low)
- `VS_POL`, 0 — active level of `vga_vs`
- `CNT_W`, 11 — counter and address width; must hold both totals
- `COLOR_W`, 8 — bits per colour channel
- `PIX_LATENCY`, 1 — cycles from address out to `rgb_in` valid, range 0..4
- `clock`  in  1  pixel clock; the only clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `rgb_in`  in  3*COLOR_W  pixel colour {R,G,B} for the address issued PIX_LATENCY cycles earlier
- `x_addr`  out  CNT_W  pixel column 0..H_ACTIVE-1; 0 when `addr_valid` is low
- `y_addr`  out  CNT_W  pixel row 0..V_ACTIVE-1; 0 when `addr_valid` is low
- `addr_valid`  out  1  address is inside the visible area
- `frame_start`  out  1  1-cycle pulse coincident with address (0,0)
- `vblank_start`  out  1  1-cycle pulse on the first address cycle after the last visible pixel of the frame
- `frame_count`  out  16  completed-frame counter, wraps at 16'hFFFF
- `vga_hs`  out  1  horizontal sync
- `vga_vs`  out  1  vertical sync
- `vga_de`  out  1  display enable, aligned with RGB
- `vga_r`, `vga_g`, `vga_b`  out  COLOR_W each  colour outputs

## Operation
- Totals: H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT and V_TOTAL likewise.
- `hc` counts 0..H_TOTAL-1 and wraps to 0. On that wrap, `vc` increments over 0..V_TOTAL-1 and wraps to 0. Each count occurs exactly once.
- Line order is sync, back porch, active, front porch.
  - Horizontal sync is active while hc < H_SYNC.
  - Vertical sync is active while vc < V_SYNC.
  - The visible area is hc in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) and vc in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE).
- Address stage (1 register): `x_addr` = hc-(H_SYNC+H_BACK) and `y_addr` = vc-(V_SYNC+V_BACK). Both are unsigned, CNT_W wide, and forced to 0 outside the visible area.
- Delay stage: `hs`, `vs` and `de` are carried through a PIX_LATENCY-deep shift register, then pass through the output register together with `rgb_in`.
- `vga_r`/`vga_g`/`vga_b` take `rgb_in` fields [3C-1:2C] / [2C-1:C] / [C-1:0] (C = COLOR_W) when the delayed `de` is 1, otherwise 0.
- Sync output level is HS_POL/VS_POL when active, otherwise the inverse.
- `frame_count` increments in the same cycle that `frame_start` is high.
- Reset, asynchronous and valid mid-frame:
  - counters, pipeline and `frame_count` go to 0;
  - `addr_valid`, `frame_start`, `vblank_start` and `vga_de` go to 0; RGB outputs go to 0;
  - `vga_hs` = ~HS_POL and `vga_vs` = ~VS_POL.
  - After release, counting starts from hc=vc=0.

## Timing
- A counter state registered at edge k produces its address outputs at edge k+1.
- `rgb_in` must be valid between edges k+1+PIX_LATENCY and k+2+PIX_LATENCY. It is sampled at edge k+2+PIX_LATENCY.
- `vga_hs`, `vga_vs`, `vga_de` and RGB for that state update at edge k+2+PIX_LATENCY. The latency is equal for all of them.
- `vga_de` therefore trails `addr_valid` by exactly PIX_LATENCY+1 cycles.
- The first sync pulse reaches the pins 2+PIX_LATENCY cycles after reset release.

## Configuration
- `VGA_TIMING_TESTPAT_EN` defined:
  - adds input `test_en` (1 bit);
  - while `test_en`=1, `rgb_in` is ignored and 8 vertical bars are output, each floor(H_ACTIVE/8) pixels wide, with the last bar absorbing any remainder;
  - bar order is FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000 (values shown for COLOR_W=8; each channel is all-ones or zero);
  - the bar index comes from a per-line counter and is carried through the same delay as `de`.
- Not defined: the `test_en` port is absent and `rgb_in` is always used.

## Test plan
- Defaults, free run → `vga_hs` period 800 cycles, low for 96; `vga_vs` period 420000 cycles, low for 1600; `vga_de` high 640 cycles per line on 480 lines.
- Defaults, from reset release → first `addr_valid` and `frame_start` at cycle 28145 with x=y=0. Exactly 307200 `addr_valid` cycles per frame. `vblank_start` occurs once per frame. `frame_count` reads 3 after three `frame_start` pulses.
- PIX_LATENCY=1; `rgb_in` = {x[7:0], y[7:0], 8'hA5}, registered one cycle after the address → every `vga_de` cycle shows `vga_r`=x, `vga_g`=y, `vga_b`=A5. `vga_de` rises 2 cycles after `addr_valid`.
- `rgb_in`=FFFFFF held constant → RGB is 0 in every cycle where `vga_de`=0.
- Reset asserted on line 200 mid-line → in the same cycle: `vga_hs`=`vga_vs`=1, `vga_de`=0, RGB 0, `frame_count` 0. After release the waveform matches scenario 2 cycle-for-cycle.
- Override 800x600: H 128/88/800/40, V 4/23/600/1, HS_POL=VS_POL=1 → `vga_hs` high 128 of 1056 cycles, `vga_vs` high 4 of 628 lines.
  - With `VGA_TIMING_TESTPAT_EN` and `test_en`=1: pixel 0 = FFFFFF, pixel 100 = FFFF00, pixel 799 = 000000.
